hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_perf_cnt.sv | 33 +++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional perf counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_X0         = 5'd0;
    localparam int         MD_TIMEOUT_DEF = 64;
    localparam int         CNT_W_DEF      = 32;

    // True when an operand the ID instruction actually reads names the EX destination.
    function automatic logic src_hit(input logic       use_src,
                                     input logic [4:0] src_id,
                                     input logic [4:0] dst_id);
        return use_src && (src_id == dst_id);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three saturating event counters (load-use stalls, branch flushes, mul/div busy cycles).
// Instantiated by hazard_ctrl only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             md_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] md_cnt
);

    // Holds at all-ones instead of wrapping so a long run never reads as a short one.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            md_cnt    <= '0;
        end else begin
            stall_cnt <= bump(stall_cnt, stall_inc);
            flush_cnt <= bump(flush_cnt, flush_inc);
            md_cnt    <= bump(md_cnt, md_inc);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use bubbles, branch flushes, mul/div freeze.
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt / md_cnt performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1_id,
    input  logic [4:0] id_rs2_id,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rdst_id,
    input  logic       ex_mem_read,
    input  logic       ex_br_taken,
    input  logic       ex_md_start,
    input  logic       md_done,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_we,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       md_busy,
    output logic       md_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] md_cnt
`endif
);

    localparam int            TW       = $clog2(MD_TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(MD_TIMEOUT - 1);

    state_e        state;
    state_e        state_nxt;
    logic [TW-1:0] tmr;
    logic          load_use;
    logic          err_set;

    // A load into x0 never produces a value, so it can never be a hazard.
    assign load_use = ex_mem_read && (ex_rdst_id != REG_X0) &&
                      (src_hit(id_use_rs1, id_rs1_id, ex_rdst_id) ||
                       src_hit(id_use_rs2, id_rs2_id, ex_rdst_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            tmr    <= '0;
            md_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == MD_BUSY) && (state_nxt == MD_BUSY)) begin
                tmr <= tmr + TW'(1);
            end else begin
                tmr <= '0;
            end
            if (err_set) begin
                md_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        case (state)
            RUN: begin
                // Priority: mul/div issue, then redirect (squashes the stalled op), then load-use.
                if (ex_md_start) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_we     = 1'b0;
                    ex_mem_flush = 1'b1;
                    state_nxt    = MD_BUSY;
                end else if (ex_br_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (md_done) begin
                    state_nxt = RUN;
                end else begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_we     = 1'b0;
                    ex_mem_flush = 1'b1;
                    if (tmr == TMR_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
        // Hold every stage register frozen and empty while reset is asserted.
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            md_busy      = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_evt;
    logic flush_evt;
    logic md_evt;

    assign stall_evt = (state == RUN) && !ex_md_start && !ex_br_taken && load_use;
    assign flush_evt = (state == RUN) && !ex_md_start && ex_br_taken;
    assign md_evt    = (state == MD_BUSY);

    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_inc(stall_evt),
        .flush_inc(flush_evt),
        .md_inc   (md_evt),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .md_cnt   (md_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (default build, MD_TIMEOUT=8).
// Expected output vectors are queued as stimulus is driven and popped at the following negedge.
module tb_hazard_ctrl;

    // Output vector: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush, md_busy, md_err}
    localparam logic [7:0] NORM  = 8'b1101_0000;
    localparam logic [7:0] STALL = 8'b0001_1000;
    localparam logic [7:0] BRFL  = 8'b1111_1000;
    localparam logic [7:0] MDST  = 8'b0000_0100;
    localparam logic [7:0] BUSY  = 8'b0000_0110;
    localparam logic [7:0] DONE  = 8'b1101_0010;
    localparam logic [7:0] RST   = 8'b0010_1100;
    localparam logic [7:0] ERR   = 8'b0000_0001;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic       br;
        logic       ms;
        logic       md;
    } stim_t;

    localparam stim_t IDLE = '0;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_id;
    logic [4:0] id_rs2_id;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rdst_id;
    logic       ex_mem_read;
    logic       ex_br_taken;
    logic       ex_md_start;
    logic       md_done;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_we;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       md_busy;
    logic       md_err;
    logic [7:0] outs;

    logic [7:0] exp_q[$];
    int         n_chk;
    int         n_fail;

    assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush, md_busy, md_err};

    hazard_ctrl #(
        .MD_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1_id   (id_rs1_id),
        .id_rs2_id   (id_rs2_id),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rdst_id  (ex_rdst_id),
        .ex_mem_read (ex_mem_read),
        .ex_br_taken (ex_br_taken),
        .ex_md_start (ex_md_start),
        .md_done     (md_done),
        .pc_we       (pc_we),
        .if_id_we    (if_id_we),
        .if_id_flush (if_id_flush),
        .id_ex_we    (id_ex_we),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .md_busy     (md_busy),
        .md_err      (md_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver
    task automatic set_inputs(input stim_t s);
        ex_mem_read = s.mr;
        ex_rdst_id  = s.rd;
        id_rs1_id   = s.r1;
        id_use_rs1  = s.u1;
        id_rs2_id   = s.r2;
        id_use_rs2  = s.u2;
        ex_br_taken = s.br;
        ex_md_start = s.ms;
        md_done     = s.md;
    endtask

    task automatic drive(input stim_t s, input logic [7:0] exp);
        @(posedge clk);
        #1;
        set_inputs(s);
        exp_q.push_back(exp);
    endtask

    function automatic stim_t lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2);
        stim_t s;
        s    = IDLE;
        s.mr = 1'b1;
        s.rd = rd;
        s.r1 = r1;
        s.u1 = u1;
        s.r2 = r2;
        s.u2 = u2;
        return s;
    endfunction

    task automatic test_reset();
        logic [7:0] e;
        rst_n = 1'b0;
        set_inputs(IDLE);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) set_inputs(lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0));
            exp_q.push_back(RST);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b expected %b", i, outs, e);
            end
        end
        set_inputs(IDLE);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        stim_t      tab[6];
        logic [7:0] etab[6];
        stim_t      s;
        logic [7:0] e;
        logic       hit;
        tab[0] = lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);   etab[0] = STALL;
        tab[1] = IDLE;                               etab[1] = NORM;
        tab[2] = lu(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);   etab[2] = STALL;
        tab[3] = IDLE;                               etab[3] = NORM;
        tab[4] = lu(5'd31, 5'd31, 1'b1, 5'd31, 1'b1); etab[4] = STALL;
        tab[5] = lu(5'd7, 5'd6, 1'b1, 5'd8, 1'b1);   etab[5] = NORM;
        for (int i = 0; i < 6; i++) begin
            drive(tab[i], etab[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, outs, e);
            end
        end
        for (int i = 0; i < 24; i++) begin
            s    = IDLE;
            s.mr = 1'($urandom_range(0, 1));
            s.rd = 5'($urandom_range(0, 3));
            s.r1 = 5'($urandom_range(0, 3));
            s.r2 = 5'($urandom_range(0, 3));
            s.u1 = 1'($urandom_range(0, 1));
            s.u2 = 1'($urandom_range(0, 1));
            hit  = s.mr && (s.rd != 5'd0) &&
                   ((s.u1 && (s.r1 == s.rd)) || (s.u2 && (s.r2 == s.rd)));
            drive(s, hit ? STALL : NORM);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL load_use_rand[%0d]: got %b expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_x0_unused();
        stim_t      tab[4];
        logic [7:0] e;
        tab[0] = lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        tab[1] = lu(5'd12, 5'd3, 1'b1, 5'd12, 1'b0);
        tab[2] = lu(5'd12, 5'd12, 1'b0, 5'd4, 1'b1);
        tab[3] = lu(5'd12, 5'd12, 1'b1, 5'd12, 1'b1);
        tab[3].mr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(tab[i], NORM);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL x0_unused[%0d]: got %b expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_branch();
        stim_t      tab[4];
        logic [7:0] etab[4];
        logic [7:0] e;
        tab[0] = lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); tab[0].br = 1'b1; etab[0] = BRFL;
        tab[1] = IDLE;                             etab[1] = NORM;
        tab[2] = IDLE;                             tab[2].br = 1'b1; etab[2] = BRFL;
        tab[3] = IDLE;                             tab[3].md = 1'b1; etab[3] = NORM;
        for (int i = 0; i < 4; i++) begin
            drive(tab[i], etab[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b expected %b", i, outs, e);
            end
        end
    endtask

    // Mul/div that completes after n_busy busy cycles (done in the last one); start may carry
    // a simultaneous branch + load-use to exercise issue priority.
    task automatic test_md_done(input int n_busy, input logic [7:0] err_bits);
        stim_t      s;
        logic [7:0] e;
        for (int i = 0; i < n_busy + 2; i++) begin
            s = IDLE;
            if (i == 0) begin
                s    = lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
                s.br = 1'b1;
                s.ms = 1'b1;
                drive(s, MDST | err_bits);
            end else if (i < n_busy) begin
                drive(s, BUSY | err_bits);
            end else if (i == n_busy) begin
                s.md = 1'b1;
                drive(s, DONE | err_bits);
            end else begin
                drive(s, NORM | err_bits);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL md_done_%0d[%0d]: got %b expected %b", n_busy, i, outs, e);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t      s;
        logic [7:0] e;
        for (int i = 0; i < 14; i++) begin
            s = IDLE;
            if (i == 0) begin
                s.ms = 1'b1;
                drive(s, MDST);
            end else if (i <= 8) begin
                drive(s, BUSY);
            end else if (i == 9) begin
                drive(s, NORM | ERR);
            end else if (i == 10) begin
                s.md = 1'b1;
                drive(s, NORM | ERR);
            end else if (i == 11) begin
                drive(lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), STALL | ERR);
            end else begin
                drive(s, NORM | ERR);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, outs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t      s;
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            s    = IDLE;
            s.ms = (i == 0);
            drive(s, (i == 0) ? (MDST | ERR) : (BUSY | ERR));
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: got %b expected %b", i, outs, e);
            end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(RST);
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (outs !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected %b", outs, e);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? IDLE : lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
            drive(s, (i == 0) ? NORM : STALL);
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL async_post[%0d]: got %b expected %b", i, outs, e);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_x0_unused();
        test_branch();
        test_md_done(5, 8'b0);
        test_md_done(8, 8'b0);
        test_timeout();
        test_md_done(3, ERR);
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
